// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1280x720@60 raster timing with registered sync/de/coords.
// VGA_TIMING_ALIGN_EN adds one en-qualified stage on hsync, vsync and de.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        frame_tick
);

    localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
    localparam logic [11:0] H_ACT_BEG = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_ACT_END = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_ACT_BEG = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_ACT_END = 12'(V_SYNC + V_BP + V_ACTIVE);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        hs_c;
    logic        vs_c;
    logic        de_c;
    logic        tick_c;
    logic [11:0] x_c;
    logic [11:0] y_c;
    logic        hs_r;
    logic        vs_r;
    logic        de_r;

    always_comb begin
        h_last = (h_cnt == H_TOTAL - 12'd1);
        v_last = (v_cnt == V_TOTAL - 12'd1);
        hs_c   = (h_cnt < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
        vs_c   = (v_cnt < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
        de_c   = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                 (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        x_c    = de_c ? h_cnt - H_ACT_BEG : 12'hFFF;
        y_c    = de_c ? v_cnt - V_ACT_BEG : 12'hFFF;
        tick_c = h_last && (v_cnt == V_ACT_END - 12'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Outputs decode the counter value seen before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r       <= ~SYNC_POL;
            vs_r       <= ~SYNC_POL;
            de_r       <= 1'b0;
            x_pos      <= 12'hFFF;
            y_pos      <= 12'hFFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= en & tick_c;
            if (en) begin
                hs_r  <= hs_c;
                vs_r  <= vs_c;
                de_r  <= de_c;
                x_pos <= x_c;
                y_pos <= y_c;
            end
        end
    end

`ifdef VGA_TIMING_ALIGN_EN
    logic hs_d;
    logic vs_d;
    logic de_d;

    // Matches the registered colour output of the pixel stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d <= ~SYNC_POL;
            vs_d <= ~SYNC_POL;
            de_d <= 1'b0;
        end else if (en) begin
            hs_d <= hs_r;
            vs_d <= vs_r;
            de_d <= de_r;
        end
    end

    assign hsync = hs_d;
    assign vsync = vs_d;
    assign de    = de_d;
`else
    assign hsync = hs_r;
    assign vsync = vs_r;
    assign de    = de_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a small-raster and a default-raster instance
// against a position-arithmetic model every cycle, plus literal checks.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ft;
    } out_t;

    localparam out_t RST = '{hs: 1'b0, vs: 1'b0, de: 1'b0,
                             x: 12'hFFF, y: 12'hFFF, ft: 1'b0};

    // small raster: 28 clks/line, 13 lines/frame, 364 clks/frame
    localparam int SHA = 16, SHF = 3, SHS = 4, SHB = 5;
    localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 3;
    localparam int SFRAME = 364;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic chk_on = 1'b0;

    logic        hs_s, vs_s, de_s, ft_s;
    logic [11:0] x_s, y_s;
    logic        hs_d, vs_d, de_d, ft_d;
    logic [11:0] x_d, y_d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .x_pos(x_s), .y_pos(y_s), .frame_tick(ft_s)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hs_d), .vsync(vs_d), .de(de_d),
        .x_pos(x_d), .y_pos(y_d), .frame_tick(ft_d)
    );

    function automatic out_t model(longint n, int ha, int hf, int hsw,
                                   int hb, int va, int vf, int vsw, int vb);
        out_t   m;
        longint ht;
        longint vt;
        longint h;
        longint v;
        ht   = hsw + hb + ha + hf;
        vt   = vsw + vb + va + vf;
        h    = n % ht;
        v    = (n / ht) % vt;
        m.hs = (h < hsw);
        m.vs = (v < vsw);
        m.de = (h >= hsw + hb) && (h < hsw + hb + ha) &&
               (v >= vsw + vb) && (v < vsw + vb + va);
        m.x  = m.de ? 12'(h - (hsw + hb)) : 12'hFFF;
        m.y  = m.de ? 12'(v - (vsw + vb)) : 12'hFFF;
        m.ft = (h == ht - 1) && (v == vsw + vb + va - 1);
        return m;
    endfunction

    longint n_s = 0;
    longint n_d = 0;
    out_t   exp_s = RST;
    out_t   exp_d = RST;
    out_t   pip_s = RST;
    out_t   pip_d = RST;

    function automatic out_t align(out_t cur, out_t prev);
        out_t r;
        r = cur;
`ifdef VGA_TIMING_ALIGN_EN
        r.hs = prev.hs;
        r.vs = prev.vs;
        r.de = prev.de;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        out_t cs;
        out_t cd;
        if (!rst_n) begin
            n_s   = 0;
            n_d   = 0;
            exp_s = RST;
            exp_d = RST;
            pip_s = RST;
            pip_d = RST;
        end else if (en) begin
            cs    = model(n_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
            cd    = model(n_d, 1280, 110, 40, 220, 720, 5, 5, 20);
            exp_s = align(cs, pip_s);
            exp_d = align(cd, pip_d);
            pip_s = cs;
            pip_d = cd;
            n_s++;
            n_d++;
        end else begin
            exp_s.ft = 1'b0;
            exp_d.ft = 1'b0;
        end
    end

    task automatic cmp(string nm, logic [11:0] act, logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("s_hsync", 12'(hs_s), 12'(exp_s.hs));
            cmp("s_vsync", 12'(vs_s), 12'(exp_s.vs));
            cmp("s_de", 12'(de_s), 12'(exp_s.de));
            cmp("s_x", x_s, exp_s.x);
            cmp("s_y", y_s, exp_s.y);
            cmp("s_tick", 12'(ft_s), 12'(exp_s.ft));
            cmp("d_hsync", 12'(hs_d), 12'(exp_d.hs));
            cmp("d_vsync", 12'(vs_d), 12'(exp_d.vs));
            cmp("d_de", 12'(de_d), 12'(exp_d.de));
            cmp("d_x", x_d, exp_d.x);
            cmp("d_y", y_d, exp_d.y);
            cmp("d_tick", 12'(ft_d), 12'(exp_d.ft));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // First line after reset release on the default raster.
    task automatic first_line(string tag);
        int hs_n = 0, vs_n = 0, de_n = 0, xy_bad = 0, last_hi = -1;
        int s_hs_n = 0;
        logic first_hs = 1'b0;
        for (int i = 0; i < 1650; i++) begin
            step();
            if (i == 0) first_hs = hs_d;
            if (hs_d) begin
                hs_n++;
                last_hi = i;
            end
            if (vs_d) vs_n++;
            if (de_d) de_n++;
            if (x_d != 12'hFFF || y_d != 12'hFFF) xy_bad++;
            if (i < 28 && hs_s) s_hs_n++;
        end
        cmp({tag, "_first_hs"}, 12'(first_hs), 12'd1);
        cmp({tag, "_hs_width"}, 12'(hs_n), 12'd40);
        cmp({tag, "_hs_last"}, 12'(last_hi), 12'd39);
        cmp({tag, "_vs_line"}, 12'(vs_n), 12'd1650);
        cmp({tag, "_de_line0"}, 12'(de_n), 12'd0);
        cmp({tag, "_xy_line0"}, 12'(xy_bad), 12'd0);
        cmp({tag, "_s_hs_width"}, 12'(s_hs_n), 12'd4);
    endtask

    initial begin
        int de_n, run, max_run, max_y, rise_x, ticks, t0, gap, lx, ly;
        logic prev_de;
        bit found;

        step();
        chk_on = 1'b1;
        step();
        cmp("rst_hs_d", 12'(hs_d), 12'd0);
        cmp("rst_x_d", x_d, 12'hFFF);
        cmp("rst_de_s", 12'(de_s), 12'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        first_line("t1");

        // one small frame: active window shape
        de_n = 0; run = 0; max_run = 0; max_y = 0; rise_x = -1;
        prev_de = de_s;
        for (int i = 0; i < SFRAME; i++) begin
            step();
            if (de_s) begin
                de_n++;
                run++;
                if (run > max_run) max_run = run;
                if (int'(y_s) > max_y) max_y = int'(y_s);
                if (!prev_de && rise_x < 0) rise_x = int'(x_s);
            end else begin
                run = 0;
            end
            prev_de = de_s;
        end
        cmp("t2_de_count", 12'(de_n), 12'd96);
        cmp("t2_de_run", 12'(max_run), 12'd16);
        cmp("t2_y_max", 12'(max_y), 12'd5);
`ifdef VGA_TIMING_ALIGN_EN
        cmp("t6_x_at_de_rise", 12'(rise_x), 12'd1);
`else
        cmp("t6_x_at_de_rise", 12'(rise_x), 12'd0);
`endif

        // two small frames: tick count, spacing and position
        ticks = 0; t0 = 0; gap = 0; lx = -1; ly = -1;
        for (int i = 0; i < 2 * SFRAME; i++) begin
            step();
            if (ft_s) begin
                ticks++;
                if (ticks == 2) gap = i - t0;
                t0 = i;
                cmp("t3_tick_last_x", 12'(lx), 12'd15);
                cmp("t3_tick_last_y", 12'(ly), 12'd5);
            end
            if (x_s != 12'hFFF) begin
                lx = int'(x_s);
                ly = int'(y_s);
            end
        end
        cmp("t3_ticks", 12'(ticks), 12'd2);
        cmp("t3_gap", 12'(gap), 12'(SFRAME));

        // en toggling every clk doubles every period
        ticks = 0; t0 = 0; gap = 0; run = 0; max_run = 0;
        for (int i = 0; i < 4 * SFRAME; i++) begin
            en = ~en;
            step();
            if (hs_s) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (ft_s) begin
                ticks++;
                if (ticks == 2) gap = i - t0;
                t0 = i;
            end
        end
        en = 1'b1;
        cmp("t4_hs_width", 12'(max_run), 12'd8);
        cmp("t4_ticks", 12'(ticks), 12'd2);
        cmp("t4_gap", 12'(gap), 12'(2 * SFRAME));

        // reset mid-frame on the small raster
        found = 1'b0;
        for (int i = 0; i < 2 * SFRAME && !found; i++) begin
            step();
            if ((n_s % 28) == 12 && ((n_s / 28) % 13) == 4) found = 1'b1;
        end
        cmp("t5_reach_pos", 12'(found), 12'd1);
        rst_n = 1'b0;
        #1;
        cmp("t5_async_hs_s", 12'(hs_s), 12'd0);
        cmp("t5_async_de_s", 12'(de_s), 12'd0);
        cmp("t5_async_x_s", x_s, 12'hFFF);
        cmp("t5_async_y_s", y_s, 12'hFFF);
        cmp("t5_async_hs_d", 12'(hs_d), 12'd0);
        repeat (3) step();
        rst_n = 1'b1;
        first_line("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
